// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared state encoding, command layout and counter type for the SPI register target.
package spi_target_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;
    localparam int CMD_RW_BIT = 7;
    localparam int BYTE_W = 8;
    typedef logic [2:0] bit_cnt_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizer plus an edge register producing one-cycle rise/fall pulses.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[1:0], din};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {3{RST_VAL}};
        else     sync_q <= sync_d;
    end
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_target_regs.sv
// spi_target_regs: oversampled SPI target (mode 3, MSB first) fronting a small register file.
// Optional SPI_TARGET_IRQ_EN adds a sticky irq set by received bytes, acked via the last register.
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h51,
    parameter int         DEPTH       = 8,
    parameter int         AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    output logic          rx_valid,
    output logic [AW-1:0] rx_addr,
    output logic [7:0]    rx_data,
    output logic          busy,
    output logic          frame_err,
    output logic          irq
);
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    // Idle levels as reset values: sclk idles high, and a cs already high must not look like a rise.
    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk (.clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_sync #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .rst(rst), .din(cs),   .rise(cs_rise),   .fall(cs_fall));

    logic [1:0] mosi_q, mosi_d;
    state_t state_q, state_d;
    bit_cnt_t bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0] sh_q, sh_d;
    logic [BYTE_W-1:0] tx_q, tx_d, byte_in;
    logic [AW-1:0] ptr_q, ptr_d, rx_addr_q, rx_addr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] regs_q [DEPTH];
    logic [7:0] regs_d [DEPTH];
    logic wr_q, wr_d, oe_q, oe_d, rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
    logic last_bit, abort;

    assign byte_in  = {sh_q, mosi_q[1]};
    assign last_bit = sclk_rise && bit_cnt_q == 3'd7;
    assign abort    = state_q != IDLE && cs_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) state_d = IDLE;
        else if (state_q == IDLE && cs_rise) state_d = CMD;
        else if (state_q == CMD && last_bit) state_d = byte_in[6:0] == DEVICE_ADDR ? DATA : IGNORE;
    end

    always_comb begin
        mosi_d      = {mosi_q[0], mosi};
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        wr_d        = wr_q;
        oe_d        = oe_q;
        rx_valid_d  = 1'b0;
        rx_addr_d   = rx_addr_q;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        regs_d      = regs_q;
        if (loc_we) regs_d[loc_addr] = loc_wdata;
        if (abort) begin
            frame_err_d = bit_cnt_q != '0;
            bit_cnt_d   = '0;
            tx_d        = '0;
            oe_d        = 1'b0;
        end else if (state_q == IDLE) begin
            bit_cnt_d = '0;
            sh_d      = '0;
            tx_d      = '0;
            oe_d      = 1'b0;
            ptr_d     = '0;
        end else begin
            if (sclk_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                sh_d      = byte_in[BYTE_W-2:0];
            end
            if (state_q == CMD && last_bit) begin
                ptr_d = '0;
                wr_d  = byte_in[CMD_RW_BIT];
            end
            // SPI commit is applied after the local write so it wins on a shared index.
            if (state_q == DATA && wr_q && last_bit) begin
                regs_d[ptr_q] = byte_in;
                rx_valid_d    = 1'b1;
                rx_addr_d     = ptr_q;
                rx_data_d     = byte_in;
                ptr_d         = ptr_q + AW'(1);
            end
            // A falling edge at a byte boundary loads the next register; otherwise it shifts.
            if (state_q == DATA && !wr_q && sclk_fall) begin
                tx_d  = bit_cnt_q == '0 ? regs_q[ptr_q] : {tx_q[BYTE_W-2:0], 1'b0};
                ptr_d = bit_cnt_q == '0 ? ptr_q + AW'(1) : ptr_q;
                oe_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_q      <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            wr_q        <= 1'b0;
            oe_q        <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_addr_q   <= '0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            regs_q      <= '{default: '0};
        end else begin
            mosi_q      <= mosi_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            wr_q        <= wr_d;
            oe_q        <= oe_d;
            rx_valid_q  <= rx_valid_d;
            rx_addr_q   <= rx_addr_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

`ifdef SPI_TARGET_IRQ_EN
    logic irq_q, irq_d;
    always_comb irq_d = rx_valid_d | (irq_q & ~(loc_we && loc_addr == AW'(DEPTH - 1)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign miso      = oe_q & tx_q[BYTE_W-1];
    assign miso_oe   = oe_q;
    assign rx_valid  = rx_valid_q;
    assign rx_addr   = rx_addr_q;
    assign rx_data   = rx_data_q;
    assign busy      = state_q != IDLE;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_target_regs.sv
// tb_spi_target_regs: scoreboard bench driving SPI mode-3 frames; a register model predicts reads and rx events.
module tb_spi_target_regs;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b1, cs = 1'b0, mosi = 1'b0, loc_we = 1'b0;
    logic [AW-1:0] loc_addr = '0;
    logic [7:0] loc_wdata = '0;
    logic miso, miso_oe, rx_valid, busy, frame_err, irq;
    logic [AW-1:0] rx_addr;
    logic [7:0] rx_data;

    spi_target_regs #(.DEVICE_ADDR(7'h51), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .rx_valid(rx_valid),
        .rx_addr(rx_addr), .rx_data(rx_data), .busy(busy), .frame_err(frame_err), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} rx_t;
    rx_t rx_q[$];
    logic [7:0] mdl [DEPTH];
    logic [7:0] wbuf [16];
    int n_chk = 0, n_pass = 0, fe_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin : mon
        rx_t e;
        if (frame_err) fe_cnt++;
        if (rx_valid) begin
            chk("rx_pending", rx_q.size() != 0, 1);
            if (rx_q.size() != 0) begin
                e = rx_q.pop_front();
                chk("rx_addr", rx_addr, e.a);
                chk("rx_data", rx_data, e.d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic spi_byte(input logic [7:0] b, input int nb, output logic [7:0] r,
                            output logic oe_any, output logic oe_all);
        r = '0; oe_any = 1'b0; oe_all = 1'b1;
        for (int i = 7; i > 7 - nb; i--) begin
            sclk = 1'b0; mosi = b[i];
            repeat (5) @(negedge clk);
            r[i] = miso; oe_any |= miso_oe; oe_all &= miso_oe;
            sclk = 1'b1;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic cs_start();
        @(negedge clk); cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk); loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge clk); loc_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic wr_frame(input logic [6:0] dev, input int n);
        logic [7:0] r;
        logic any, all;
        cs_start();
        spi_byte({1'b1, dev}, 8, r, any, all);
        chk("busy_in_frame", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (dev == 7'h51) begin
                rx_q.push_back('{a: AW'(i % DEPTH), d: wbuf[i]});
                mdl[i % DEPTH] = wbuf[i];
            end
            spi_byte(wbuf[i], 8, r, any, all);
            chk("oe_write", any, 0);
        end
        chk("busy_before_cs_low", busy, 1);
        cs_end();
        chk("busy_after_cs_low", busy, 0);
    endtask

    task automatic rd_frame(input int n);
        logic [7:0] r;
        logic any, all;
        cs_start();
        spi_byte(8'h51, 8, r, any, all);
        chk("oe_cmd", any, 0);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, 8, r, any, all);
            chk("rd_data", r, mdl[i % DEPTH]);
            chk("oe_data", all, 1);
        end
        cs_end();
        chk("oe_after_frame", miso_oe, 0);
    endtask

    initial begin
        logic [7:0] r;
        logic any, all;
        int fe0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        // cs held high across reset release must not start a frame
        cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_addr", rx_addr, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_frame_from_high_cs", busy, 0);
        cs = 1'b0;
        repeat (6) @(negedge clk);

        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        wr_frame(7'h51, 2);
        chk("no_frame_err_write", fe_cnt, 0);
`ifdef SPI_TARGET_IRQ_EN
        chk("irq_set", irq, 1);
        loc_write(3'd7, 8'h11);
        repeat (2) @(negedge clk);
        chk("irq_cleared", irq, 0);
`else
        chk("irq_tied_low", irq, 0);
`endif

        loc_write(3'd2, 8'h96);
        rd_frame(3);

        wbuf[0] = 8'hFF;
        wr_frame(7'h52, 1);
        rd_frame(3);

        for (int i = 0; i < 9; i++) wbuf[i] = 8'(i);
        wr_frame(7'h51, 9);
        chk("wrap_reg0", mdl[0], 8'h08);
        rd_frame(8);

        fe0 = fe_cnt;
        cs_start();
        spi_byte(8'hD1, 8, r, any, all);
        spi_byte(8'hFF, 5, r, any, all);
        cs_end();
        chk("frame_err_once", fe_cnt - fe0, 1);
        rd_frame(1);
        wbuf[0] = 8'h77;
        wr_frame(7'h51, 1);
        rd_frame(2);

        cs_start();
        spi_byte(8'hD1, 4, r, any, all);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_oe", miso_oe, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_irq", irq, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        fe0 = fe_cnt;
        repeat (4) @(negedge clk);
        spi_byte(8'hD1, 8, r, any, all);
        spi_byte(8'h5A, 8, r, any, all);
        chk("after_rst_still_idle", busy, 0);
        cs_end();
        chk("after_rst_no_frame_err", fe_cnt - fe0, 0);
        wbuf[0] = 8'h5A;
        wr_frame(7'h51, 1);
        rd_frame(2);

        repeat (4) @(negedge clk);
        chk("rx_leftover", rx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
